ddr_refresh_arbiter: RTL and testbench

Sequences refresh against host read/write traffic for the DDR4 controller. It shares the single command path between the host command stream and a periodic refresh requester. Refresh is issued as PRECHARGE-ALL followed by REFRESH, with tRP and tRFC enforced. The block sits between the host command handshake (`cmd_rdy`) and the read/write engine, and gates when the engine may accept a new host command.

---
 rtl/ddr_refresh_arbiter_pkg.sv | 8 +
 rtl/ddr_refresh_arbiter_if.sv | 13 +
 rtl/ddr_refi_timer.sv | 25 ++
 rtl/ddr_refresh_arbiter.sv | 79 +++++++
 tb/tb_ddr_refresh_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ddr_refresh_arbiter_pkg.sv
// ddr_pkg: arbiter state encoding and default DDR4 refresh timing
package ddr_pkg;
  typedef enum logic [2:0] {IDLE, HOST, PRE, WAIT_RP, REF, WAIT_RFC} arb_state_e;
  localparam int DDR_T_REFI = 6240;
  localparam int DDR_T_RFC = 280;
  localparam int DDR_T_RP = 14;
  localparam int DDR_MAX_POSTPONE = 8;
endpackage

// File: rtl/ddr_refresh_arbiter_if.sv
// ddr_refresh_arbiter_if: host command handshake and refresh status bundle
interface ddr_refresh_arbiter_if;
  logic cmd_rdy;
  logic host_gnt;
  logic host_done;
  logic pre_all;
  logic ref_cmd;
  logic ref_busy;
  logic [3:0] ref_pending;
  logic ref_overflow;
  modport master(output cmd_rdy, host_done, input host_gnt, pre_all, ref_cmd, ref_busy, ref_pending, ref_overflow);
  modport slave(input cmd_rdy, host_done, output host_gnt, pre_all, ref_cmd, ref_busy, ref_pending, ref_overflow);
endinterface

// File: rtl/ddr_refi_timer.sv
// ddr_refi_timer: free-running tREFI counter emitting a registered one-cycle tick on wrap
module ddr_refi_timer
  import ddr_pkg::*;
#(
  parameter int T_REFI = DDR_T_REFI,
  parameter int CNT_W = 16
) (
  input  logic CK_t,
  input  logic reset,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CNT_W'(T_REFI - 1);
  // count 0..T_REFI-1; tick lands T_REFI cycles after reset release
  always_ff @(posedge CK_t) begin
    if (reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      tick <= wrap;
    end
  end
endmodule

// File: rtl/ddr_refresh_arbiter.sv
// ddr_refresh_arbiter: shares the command path between host traffic and PRE-ALL/REFRESH; DDR_REF_POSTPONE_EN lets refresh defer to a waiting host
module ddr_refresh_arbiter
  import ddr_pkg::*;
#(
  parameter int T_REFI = DDR_T_REFI,
  parameter int T_RFC = DDR_T_RFC,
  parameter int T_RP = DDR_T_RP,
  parameter int MAX_POSTPONE = DDR_MAX_POSTPONE,
  parameter int CNT_W = 16
) (
  input logic CK_t,
  input logic reset,
  ddr_refresh_arbiter_if.slave bus
);
  arb_state_e state, next;
  logic [CNT_W-1:0] wcnt, wcnt_next;
  logic tick, full, want_ref, dec;
  ddr_refi_timer #(.T_REFI(T_REFI), .CNT_W(CNT_W)) u_timer (
    .CK_t (CK_t),
    .reset(reset),
    .tick (tick)
  );
  assign full = bus.ref_pending == 4'(MAX_POSTPONE);
  assign dec = state == WAIT_RFC && wcnt == '0;
`ifdef DDR_REF_POSTPONE_EN
  assign want_ref = full || (bus.ref_pending != '0 && !bus.cmd_rdy);
`else
  assign want_ref = bus.ref_pending != '0;
`endif
  // next state; wait counters load remaining-cycles-minus-one on entry to each wait
  always_comb begin
    next = state;
    wcnt_next = wcnt - CNT_W'(1);
    case (state)
      IDLE:     next = want_ref ? PRE : bus.cmd_rdy ? HOST : IDLE;
      HOST:     next = bus.host_done ? IDLE : HOST;
      PRE: begin
        next = WAIT_RP;
        wcnt_next = CNT_W'(T_RP - 2);
      end
      WAIT_RP:  next = wcnt == '0 ? REF : WAIT_RP;
      REF: begin
        next = WAIT_RFC;
        wcnt_next = CNT_W'(T_RFC - 2);
      end
      WAIT_RFC: next = dec ? IDLE : WAIT_RFC;
      default:  next = IDLE;
    endcase
  end
  // state register and registered strobes decoded from the next state
  always_ff @(posedge CK_t) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      bus.host_gnt <= 1'b0;
      bus.pre_all <= 1'b0;
      bus.ref_cmd <= 1'b0;
      bus.ref_busy <= 1'b0;
    end else begin
      state <= next;
      wcnt <= wcnt_next;
      bus.host_gnt <= next == HOST;
      bus.pre_all <= next == PRE;
      bus.ref_cmd <= next == REF;
      bus.ref_busy <= next != IDLE && next != HOST;
    end
  end
  // outstanding refresh count: tick and completion cancel, ticks saturate and flag overflow
  always_ff @(posedge CK_t) begin
    if (reset) begin
      bus.ref_pending <= '0;
      bus.ref_overflow <= 1'b0;
    end else begin
      bus.ref_pending <= (tick && !dec) ? (full ? bus.ref_pending : bus.ref_pending + 4'd1) :
                         (dec && !tick) ? bus.ref_pending - 4'd1 : bus.ref_pending;
      bus.ref_overflow <= bus.ref_overflow | (tick & full);
    end
  end
endmodule

// File: tb/tb_ddr_refresh_arbiter.sv
// tb_ddr_refresh_arbiter: table, directed and random checks against a cycle-count refresh model
module tb_ddr_refresh_arbiter;
  localparam int T_REFI = 20, T_RFC = 8, T_RP = 3, MAXP = 8, REF_LEN = T_RP + T_RFC;
`ifdef DDR_REF_POSTPONE_EN
  localparam int POSTPONE = 1;
`else
  localparam int POSTPONE = 0;
`endif
  logic CK_t = 1'b0;
  logic reset = 1'b1;
  ddr_refresh_arbiter_if bus();
  ddr_refresh_arbiter #(.T_REFI(T_REFI), .T_RFC(T_RFC), .T_RP(T_RP), .MAX_POSTPONE(MAXP), .CNT_W(16)) dut (
    .CK_t (CK_t),
    .reset(reset),
    .bus  (bus)
  );
  always #5 CK_t = ~CK_t;
  int errors = 0, checks = 0, cyc = 0;
  int m_mode, m_k, m_pend, m_ovf, m_c;
  typedef struct {
    int c;
    logic gnt, pre, rc, busy;
    int pend;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_model();
    chk("m_host_gnt", int'(bus.host_gnt), int'(m_mode == 1));
    chk("m_pre_all", int'(bus.pre_all), int'(m_mode == 2 && m_k == 0));
    chk("m_ref_cmd", int'(bus.ref_cmd), int'(m_mode == 2 && m_k == T_RP));
    chk("m_ref_busy", int'(bus.ref_busy), int'(m_mode == 2));
    chk("m_ref_pending", int'(bus.ref_pending), m_pend);
    chk("m_ref_overflow", int'(bus.ref_overflow), m_ovf);
  endtask
  function automatic void model_reset();
    m_mode = 0; m_k = 0; m_pend = 0; m_ovf = 0; m_c = 0;
  endfunction
  // mode 0 idle, 1 host, 2 refresh sequence with m_k cycles elapsed since PRECHARGE-ALL
  function automatic void model_step(int cmd, int done);
    int tick = int'(m_c > 0 && m_c % T_REFI == 0);
    int fin = int'(m_mode == 2 && m_k == REF_LEN - 1);
    int p = m_pend;
    if (tick == 1 && p == MAXP) m_ovf = 1;
    if (tick == 1 && fin == 0 && p < MAXP) m_pend = p + 1;
    else if (fin == 1 && tick == 0) m_pend = p - 1;
    if (m_mode == 0) begin
      if (p == MAXP || (p > 0 && (POSTPONE == 0 || cmd == 0))) begin
        m_mode = 2;
        m_k = 0;
      end else if (cmd == 1) m_mode = 1;
    end else if (m_mode == 1) begin
      if (done == 1) m_mode = 0;
    end else if (fin == 1) m_mode = 0;
    else m_k++;
    m_c++;
  endfunction
  task automatic clk_step();
    model_step(int'(bus.cmd_rdy), int'(bus.host_done));
    @(negedge CK_t);
    cyc++;
    chk_model();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_rdy = 1'b0;
    bus.host_done = 1'b0;
    repeat (2) @(negedge CK_t);
    reset = 1'b0;
    cyc = 0;
    model_reset();
    chk_model();
  endtask
  initial begin
    tbl = '{'{0, 0, 0, 0, 0, 0}, '{20, 0, 0, 0, 0, 0}, '{21, 0, 0, 0, 0, 1}, '{22, 0, 1, 0, 1, 1},
            '{23, 0, 0, 0, 1, 1}, '{24, 0, 0, 0, 1, 1}, '{25, 0, 0, 1, 1, 1}, '{26, 0, 0, 0, 1, 1},
            '{32, 0, 0, 0, 1, 1}, '{33, 0, 0, 0, 0, 0}, '{42, 0, 1, 0, 1, 1}};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      while (cyc < tbl[i].c) clk_step();
      chk("tbl_gnt", int'(bus.host_gnt), int'(tbl[i].gnt));
      chk("tbl_pre", int'(bus.pre_all), int'(tbl[i].pre));
      chk("tbl_ref", int'(bus.ref_cmd), int'(tbl[i].rc));
      chk("tbl_busy", int'(bus.ref_busy), int'(tbl[i].busy));
      chk("tbl_pend", int'(bus.ref_pending), tbl[i].pend);
    end
    begin
      int npre = 0;
      do_reset();
      while (cyc < 5) clk_step();
      bus.cmd_rdy = 1'b1;
      clk_step();
      chk("gnt_latency", int'(bus.host_gnt), 1);
      bus.cmd_rdy = 1'b0;
      while (cyc < 12) begin
        npre += int'(bus.pre_all);
        clk_step();
      end
      chk("gnt_held", int'(bus.host_gnt), 1);
      bus.host_done = 1'b1;
      clk_step();
      bus.host_done = 1'b0;
      chk("gnt_drop", int'(bus.host_gnt), 0);
      while (cyc < 20) begin
        npre += int'(bus.pre_all);
        clk_step();
      end
      npre += int'(bus.pre_all);
      chk("no_early_pre", npre, 0);
    end
    do_reset();
    while (cyc < 21) clk_step();
    chk("c_pend", int'(bus.ref_pending), 1);
    bus.cmd_rdy = 1'b1;
    clk_step();
    chk("c_pre22", int'(bus.pre_all), 1 - POSTPONE);
    chk("c_gnt22", int'(bus.host_gnt), POSTPONE);
    while (cyc < 33) clk_step();
    chk("c_gnt33", int'(bus.host_gnt), POSTPONE);
    clk_step();
    chk("c_gnt34", int'(bus.host_gnt), 1);
    do_reset();
    while (cyc < 4) clk_step();
    bus.cmd_rdy = 1'b1;
    clk_step();
    chk("long_gnt", int'(bus.host_gnt), 1);
    while (cyc < 60) clk_step();
    chk("long_pend2", int'(bus.ref_pending), 2);
    bus.host_done = 1'b1;
    clk_step();
    bus.host_done = 1'b0;
    chk("long_gnt_drop", int'(bus.host_gnt), 0);
    chk("long_pend3", int'(bus.ref_pending), 3);
    clk_step();
    chk("long_regnt", int'(bus.host_gnt), POSTPONE);
    chk("long_pre", int'(bus.pre_all), 1 - POSTPONE);
    do_reset();
    bus.cmd_rdy = 1'b1;
    while (cyc < 161) clk_step();
    chk("force_pend8", int'(bus.ref_pending), 8);
    while (cyc < 180) clk_step();
    chk("force_ovf0", int'(bus.ref_overflow), 0);
    clk_step();
    chk("force_ovf1", int'(bus.ref_overflow), 1);
    while (cyc < 185) clk_step();
    bus.host_done = 1'b1;
    clk_step();
    bus.host_done = 1'b0;
    chk("force_idle", int'(bus.host_gnt), 0);
    clk_step();
    chk("force_pre", int'(bus.pre_all), 1);
    chk("force_no_gnt", int'(bus.host_gnt), 0);
    while (cyc < 198) clk_step();
    chk("force_pend7", int'(bus.ref_pending), 7);
    chk("force_ovf_sticky", int'(bus.ref_overflow), 1);
    do_reset();
    while (cyc < 28) clk_step();
    chk("rst_busy_before", int'(bus.ref_busy), 1);
    reset = 1'b1;
    @(negedge CK_t);
    chk("rst_gnt", int'(bus.host_gnt), 0);
    chk("rst_pre", int'(bus.pre_all), 0);
    chk("rst_ref", int'(bus.ref_cmd), 0);
    chk("rst_busy", int'(bus.ref_busy), 0);
    chk("rst_pend", int'(bus.ref_pending), 0);
    chk("rst_ovf", int'(bus.ref_overflow), 0);
    reset = 1'b0;
    cyc = 0;
    model_reset();
    while (cyc < 20) clk_step();
    chk("rst_tick20", int'(bus.ref_pending), 0);
    clk_step();
    chk("rst_tick21", int'(bus.ref_pending), 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dp = (i / 500) % 3 == 0 ? 4 : (i / 500) % 3 == 1 ? 40 : 200;
      if (m_mode == 1) begin
        bus.cmd_rdy = $urandom_range(0, 3) == 0;
        bus.host_done = $urandom_range(0, dp - 1) == 0;
      end else begin
        if (!bus.cmd_rdy) bus.cmd_rdy = $urandom_range(0, 5) == 0;
        bus.host_done = $urandom_range(0, 19) == 0;
      end
      clk_step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
